// File: rtl/tqvp_mac_seq.sv
// tqvp_mac_seq: 16x16 signed multiply-accumulate peripheral for the TinyQV bus.
// A shift-add unit computes the product magnitude over 16 cycles. The signed
// result is then added into a 32-bit accumulator, with optional saturation.
module tqvp_mac_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);

    typedef enum logic [1:0] {StIdle, StMul, StAcc} state_e;

    state_e      state_q, state_d;
    logic [15:0] a_q, b_q;
    logic [31:0] acc_q;
    logic [15:0] count_q;
    logic        sat_en_q, irq_en_q, done_q, ovf_q;
    logic [15:0] mag_a_q, mag_b_q;
    logic        sign_q;
    logic [31:0] prod_q;
    logic [3:0]  step_q;

    logic        busy, wr_en, wr_a, wr_b, wr_ctrl, wr_acc;
    logic [31:0] wmask;
    logic        clear_req, start_go, done_w1c, ovf_w1c, acc_done;
    logic [31:0] prod_s, acc_res;
    logic [32:0] sum;
    logic        sum_ovf;
    logic        unused;

    assign unused = ^ui_in;

    assign busy    = (state_q != StIdle);
    assign wr_en   = (data_write_n != 2'b11);
    assign wr_a    = wr_en && (address == 6'h00);
    assign wr_b    = wr_en && (address == 6'h04);
    assign wr_ctrl = wr_en && (address == 6'h08);
    assign wr_acc  = wr_en && (address == 6'h0C);

    // Byte-lane mask for partial-width writes
    always_comb begin
        wmask = 32'hFFFF_FFFF;
        unique case (data_write_n)
            2'b00:   wmask = 32'h0000_00FF;
            2'b01:   wmask = 32'h0000_FFFF;
            default: wmask = 32'hFFFF_FFFF;
        endcase
    end

    // Clear beats start when both arrive in one write
    assign clear_req = wr_ctrl && data_in[1];
    assign start_go  = wr_ctrl && data_in[0] && !data_in[1] && !busy;
    assign done_w1c  = wr_ctrl && wmask[9] && data_in[9];
    assign ovf_w1c   = wr_ctrl && wmask[10] && data_in[10];
    assign acc_done  = (state_q == StAcc) && !clear_req;

    // Signed accumulate with overflow detection on the 33-bit sum
    always_comb begin
        prod_s  = sign_q ? (~prod_q + 32'd1) : prod_q;
        sum     = {acc_q[31], acc_q} + {prod_s[31], prod_s};
        sum_ovf = sum[32] ^ sum[31];
        acc_res = sum[31:0];
        if (sum_ovf && sat_en_q) begin
            acc_res = sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end

    // Next-state logic; clear aborts from any state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_go) state_d = StMul;
            StMul:   if (step_q == 4'd15) state_d = StAcc;
            StAcc:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (clear_req) begin
            state_d = StIdle;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand, control and multiplier datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            sat_en_q <= 1'b0;
            irq_en_q <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            sign_q   <= 1'b0;
            prod_q   <= '0;
            step_q   <= '0;
        end else begin
            if (wr_a && !busy) begin
                a_q <= (a_q & ~wmask[15:0]) | (data_in[15:0] & wmask[15:0]);
            end
            if (wr_b && !busy) begin
                b_q <= (b_q & ~wmask[15:0]) | (data_in[15:0] & wmask[15:0]);
            end
            if (wr_ctrl) begin
                sat_en_q <= data_in[2];
                irq_en_q <= data_in[3];
            end
            if (start_go) begin
                mag_a_q <= a_q[15] ? (~a_q + 16'd1) : a_q;
                mag_b_q <= b_q[15] ? (~b_q + 16'd1) : b_q;
                sign_q  <= a_q[15] ^ b_q[15];
                prod_q  <= '0;
                step_q  <= '0;
            end else if (state_q == StMul) begin
                if (mag_b_q[step_q]) begin
                    prod_q <= prod_q + ({16'd0, mag_a_q} << step_q);
                end
                step_q <= step_q + 4'd1;
            end
        end
    end

    // Accumulator, completion counter and sticky status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (clear_req) begin
            acc_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (acc_done) begin
                acc_q   <= acc_res;
                count_q <= count_q + 16'd1;
            end else if (wr_acc && !busy) begin
                acc_q <= (acc_q & ~wmask) | (data_in & wmask);
            end
            // Completion set wins over a same-cycle W1C
            if (acc_done) begin
                done_q <= 1'b1;
            end else if (done_w1c) begin
                done_q <= 1'b0;
            end
            if (acc_done && sum_ovf) begin
                ovf_q <= 1'b1;
            end else if (ovf_w1c) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Combinational read mux; ACC and COUNT stall while an operation is in flight
    always_comb begin
        data_out = 32'd0;
        case (address)
            6'h00:   data_out = {16'd0, a_q};
            6'h04:   data_out = {16'd0, b_q};
            6'h08:   data_out = {21'd0, ovf_q, done_q, busy, 4'd0, irq_en_q, sat_en_q, 2'd0};
            6'h0C:   data_out = acc_q;
            6'h10:   data_out = {16'd0, count_q};
            default: data_out = 32'd0;
        endcase
        data_ready = !(busy && (data_read_n != 2'b11) &&
                       ((address == 6'h0C) || (address == 6'h10)));
    end

    assign uo_out         = {busy, done_q, ovf_q, count_q[4:0]};
    assign user_interrupt = done_q & irq_en_q;

endmodule

// File: tb/tb_tqvp_mac_seq.sv
// Self-checking bench for tqvp_mac_seq: a reference model pushes expected
// accumulator values at start time; they are popped when ACC is read back.
module tb_tqvp_mac_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ui_in;
    logic [7:0]  uo_out;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic        user_interrupt;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_acc;
    logic [15:0] model_count;
    logic        model_ovf;

    tqvp_mac_seq dut (
        .clk            (clk),
        .rst            (rst),
        .ui_in          (ui_in),
        .uo_out         (uo_out),
        .address        (address),
        .data_in        (data_in),
        .data_write_n   (data_write_n),
        .data_read_n    (data_read_n),
        .data_out       (data_out),
        .data_ready     (data_ready),
        .user_interrupt (user_interrupt)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference MAC: returns {ovf, new_acc}
    function automatic logic [32:0] mac_ref(input logic [31:0] acc, input logic [15:0] a,
                                            input logic [15:0] b, input logic sat);
        longint p, s;
        logic [63:0] su;
        p  = longint'($signed(a)) * longint'($signed(b));
        s  = longint'($signed(acc)) + p;
        su = s;
        if (s > 64'sd2147483647) return {1'b1, sat ? 32'h7FFF_FFFF : su[31:0]};
        if (s < -64'sd2147483648) return {1'b1, sat ? 32'h8000_0000 : su[31:0]};
        return {1'b0, su[31:0]};
    endfunction

    task automatic bus_write(input logic [5:0] addr, input logic [31:0] val,
                             input logic [1:0] width);
        address      = addr;
        data_in      = val;
        data_write_n = width;
        @(posedge clk);
        #1;
        data_write_n = 2'b11;
    endtask

    task automatic bus_read(input logic [5:0] addr, output logic [31:0] val, output int stall);
        address     = addr;
        data_read_n = 2'b10;
        #1;
        stall = 0;
        while (!data_ready && stall < 40) begin
            stall++;
            @(posedge clk);
            #1;
        end
        if (!data_ready) check("read_timeout", {31'd0, data_ready}, 32'd1);
        val         = data_out;
        data_read_n = 2'b11;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (uo_out[7] && n < 40) begin
            n++;
            @(posedge clk);
            #1;
        end
        if (uo_out[7]) check("busy_timeout", {31'd0, uo_out[7]}, 32'd0);
    endtask

    task automatic start_mac(input logic [15:0] a, input logic [15:0] b, input logic [31:0] ctrl);
        logic [32:0] r;
        bus_write(6'h00, {16'd0, a}, 2'b10);
        bus_write(6'h04, {16'd0, b}, 2'b10);
        r = mac_ref(model_acc, a, b, ctrl[2]);
        exp_q.push_back(r[31:0]);
        model_acc   = r[31:0];
        model_ovf   = model_ovf | r[32];
        model_count = model_count + 16'd1;
        bus_write(6'h08, ctrl, 2'b10);
    endtask

    task automatic finish_mac(input string tag);
        logic [31:0] v, e;
        int s;
        bus_read(6'h0C, v, s);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check({tag, "_acc"}, v, e);
        bus_read(6'h10, v, s);
        check({tag, "_count"}, v, {16'd0, model_count});
        bus_read(6'h08, v, s);
        check({tag, "_status"}, {29'd0, v[10:8]}, {29'd0, model_ovf, 1'b1, 1'b0});
    endtask

    initial begin
        logic [31:0] v;
        int n, s;
        rst          = 1'b1;
        ui_in        = 8'h00;
        address      = 6'h00;
        data_in      = 32'd0;
        data_write_n = 2'b11;
        data_read_n  = 2'b11;
        model_acc    = 32'd0;
        model_count  = 16'd0;
        model_ovf    = 1'b0;
        #12;
        check("rst_uo_out", {24'd0, uo_out}, 32'd0);
        check("rst_irq", {31'd0, user_interrupt}, 32'd0);
        check("rst_data_out", data_out, 32'd0);
        check("rst_ready", {31'd0, data_ready}, 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 3 * -5 from zero
        start_mac(16'd3, 16'hFFFB, 32'h1);
        wait_idle(n);
        check("t1_busy_len", n, 32'd17);
        check("t1_uo_out", {24'd0, uo_out}, 32'h41);
        finish_mac("t1");

        // Positive overflow with saturation, then wrap without
        bus_write(6'h0C, 32'h7FFF_FFF0, 2'b10);
        model_acc = 32'h7FFF_FFF0;
        start_mac(16'h0100, 16'h0100, 32'h5);
        wait_idle(n);
        finish_mac("sat");
        bus_write(6'h08, 32'h400, 2'b10);
        model_ovf = 1'b0;
        check("ovf_w1c", {31'd0, uo_out[5]}, 32'd0);
        bus_write(6'h0C, 32'h7FFF_FFF0, 2'b10);
        model_acc = 32'h7FFF_FFF0;
        start_mac(16'h0100, 16'h0100, 32'h1);
        wait_idle(n);
        finish_mac("wrap");

        // Clear, then -32768 * -32768 with a W1C of done on the completion edge
        bus_write(6'h08, 32'h2, 2'b10);
        model_acc   = 32'd0;
        model_count = 16'd0;
        model_ovf   = 1'b0;
        bus_read(6'h08, v, s);
        check("clear_ctrl", v, 32'd0);
        start_mac(16'h8000, 16'h8000, 32'h1);
        repeat (16) @(posedge clk);
        #1;
        bus_write(6'h08, 32'h200, 2'b10);
        check("done_set_wins", {31'd0, uo_out[6]}, 32'd1);
        wait_idle(n);
        finish_mac("minmin");

        // Partial-width write to A
        bus_write(6'h00, 32'h0000_AAAA, 2'b10);
        bus_write(6'h00, 32'hFFFF_FF55, 2'b00);
        bus_read(6'h00, v, s);
        check("byte_write_a", v, 32'h0000_AA55);

        // Read stall on ACC; A readable and write-protected while busy
        start_mac(16'h0123, 16'h0F0F, 32'h1);
        address     = 6'h00;
        data_read_n = 2'b10;
        #1;
        check("busy_read_a", data_out, 32'h0000_0123);
        check("busy_ready_a", {31'd0, data_ready}, 32'd1);
        data_read_n = 2'b11;
        bus_write(6'h00, 32'h0000_7777, 2'b10);
        bus_read(6'h0C, v, s);
        check("stall_len", s, 32'd16);
        e_check_acc: begin
            logic [31:0] e;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            check("stall_acc", v, e);
        end
        bus_read(6'h00, v, s);
        check("a_protected", v, 32'h0000_0123);

        // Clear mid-multiply aborts the operation
        bus_write(6'h00, 32'h0000_1111, 2'b10);
        bus_write(6'h04, 32'h0000_2222, 2'b10);
        bus_write(6'h08, 32'h1, 2'b10);
        repeat (8) @(posedge clk);
        #1;
        bus_write(6'h08, 32'h2, 2'b10);
        check("abort_uo_out", {24'd0, uo_out}, 32'd0);
        repeat (25) @(posedge clk);
        #1;
        bus_read(6'h0C, v, s);
        check("abort_acc", v, 32'd0);
        bus_read(6'h10, v, s);
        check("abort_count", v, 32'd0);
        model_acc   = 32'd0;
        model_count = 16'd0;
        model_ovf   = 1'b0;

        // Reset mid-multiply
        bus_write(6'h0C, 32'h1234_5678, 2'b10);
        bus_write(6'h00, 32'h0000_0005, 2'b10);
        bus_write(6'h04, 32'h0000_0007, 2'b10);
        bus_write(6'h08, 32'hD, 2'b10);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        check("mid_rst_uo_out", {24'd0, uo_out}, 32'd0);
        repeat (20) @(posedge clk);
        #1;
        bus_read(6'h00, v, s);
        check("mid_rst_a", v, 32'd0);
        bus_read(6'h04, v, s);
        check("mid_rst_b", v, 32'd0);
        bus_read(6'h0C, v, s);
        check("mid_rst_acc", v, 32'd0);
        bus_read(6'h08, v, s);
        check("mid_rst_ctrl", v, 32'd0);
        start_mac(16'hFFFE, 16'h4000, 32'h1);
        wait_idle(n);
        check("post_rst_busy_len", n, 32'd17);
        finish_mac("post_rst");

        // Interrupt follows done once irq_en is set
        bus_write(6'h08, 32'h200, 2'b10);
        start_mac(16'd7, 16'd9, 32'h9);
        check("irq_low_busy", {31'd0, user_interrupt}, 32'd0);
        wait_idle(n);
        check("irq_high", {31'd0, user_interrupt}, 32'd1);
        finish_mac("irq");
        bus_write(6'h08, 32'h208, 2'b10);
        check("irq_cleared", {31'd0, user_interrupt}, 32'd0);
        check("done_cleared", {31'd0, uo_out[6]}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
